// File: rtl/dlx_pkg.sv
// Shared types for the DLX decode stage: ALU op enum, opcode/funct encodings,
// and the decoded instruction bundle.
// Optional build macro: DLX_DECODE_ILLEGAL_TRAP_EN adds an illegal-instruction flag.
package dlx_pkg;

   typedef enum logic [4:0] {
      AluNop  = 5'd0,
      AluAdd  = 5'd1,
      AluSub  = 5'd2,
      AluAnd  = 5'd3,
      AluOr   = 5'd4,
      AluXor  = 5'd5,
      AluSll  = 5'd6,
      AluSrl  = 5'd7,
      AluBeqz = 5'd8,
      AluBnez = 5'd9,
      AluSeq  = 5'd10,
      AluSne  = 5'd11,
      AluSlt  = 5'd12,
      AluSgt  = 5'd13,
      AluSra  = 5'd14,
      AluLink = 5'd15
   } aluop_e;

   // Primary opcodes, instr[31:26]
   localparam logic [5:0] OpRType = 6'h00;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpJal   = 6'h03;
   localparam logic [5:0] OpBeqz  = 6'h04;
   localparam logic [5:0] OpBnez  = 6'h05;
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpSubi  = 6'h0A;
   localparam logic [5:0] OpAndi  = 6'h0C;
   localparam logic [5:0] OpOri   = 6'h0D;
   localparam logic [5:0] OpXori  = 6'h0E;
   localparam logic [5:0] OpLhi   = 6'h0F;
   localparam logic [5:0] OpJr    = 6'h12;
   localparam logic [5:0] OpJalr  = 6'h13;
   localparam logic [5:0] OpSlli  = 6'h14;
   localparam logic [5:0] OpSrli  = 6'h16;
   localparam logic [5:0] OpSrai  = 6'h17;
   localparam logic [5:0] OpSeqi  = 6'h18;
   localparam logic [5:0] OpSgti  = 6'h19;
   localparam logic [5:0] OpSlti  = 6'h1A;
   localparam logic [5:0] OpSnei  = 6'h1C;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;

   // R-type function codes, instr[5:0]
   localparam logic [5:0] FnSll = 6'h04;
   localparam logic [5:0] FnSrl = 6'h06;
   localparam logic [5:0] FnSra = 6'h07;
   localparam logic [5:0] FnAdd = 6'h20;
   localparam logic [5:0] FnSub = 6'h22;
   localparam logic [5:0] FnAnd = 6'h24;
   localparam logic [5:0] FnOr  = 6'h25;
   localparam logic [5:0] FnXor = 6'h26;
   localparam logic [5:0] FnSeq = 6'h28;
   localparam logic [5:0] FnSgt = 6'h29;
   localparam logic [5:0] FnSlt = 6'h2A;
   localparam logic [5:0] FnSne = 6'h2C;

   // Width-independent decode result; the stage widens indices and immediate.
   // link=1 means rd is the link register rather than the rd field.
   typedef struct packed {
      aluop_e      aluop;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        link;
      logic [31:0] imm;
      logic        imm_sel;
      logic        pc_sel;
      logic        load;
      logic        store;
      logic        branch;
      logic        jump_reg;
      logic        jump_abs;
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
      logic        illegal;
`endif
   } dec_t;

   function automatic aluop_e funct_to_alu(input logic [5:0] funct);
      case (funct)
         FnAdd:   return AluAdd;
         FnSub:   return AluSub;
         FnAnd:   return AluAnd;
         FnOr:    return AluOr;
         FnXor:   return AluXor;
         FnSll:   return AluSll;
         FnSrl:   return AluSrl;
         FnSra:   return AluSra;
         FnSeq:   return AluSeq;
         FnSne:   return AluSne;
         FnSlt:   return AluSlt;
         FnSgt:   return AluSgt;
         default: return AluNop;
      endcase
   endfunction

   function automatic aluop_e iop_to_alu(input logic [5:0] op);
      case (op)
         OpAddi:  return AluAdd;
         OpSubi:  return AluSub;
         OpAndi:  return AluAnd;
         OpOri:   return AluOr;
         OpXori:  return AluXor;
         OpSlli:  return AluSll;
         OpSrli:  return AluSrl;
         OpSrai:  return AluSra;
         OpSeqi:  return AluSeq;
         OpSnei:  return AluSne;
         OpSlti:  return AluSlt;
         OpSgti:  return AluSgt;
         default: return AluNop;
      endcase
   endfunction

   // Arithmetic/compare immediates are signed; logical and shift ones are not.
   function automatic logic iop_signed(input logic [5:0] op);
      return (op == OpAddi) || (op == OpSubi) || (op == OpSeqi) ||
             (op == OpSnei) || (op == OpSlti) || (op == OpSgti);
   endfunction

endpackage

// File: rtl/dlx_decode_stage_if.sv
// Fetch-side and EX-side handshake bundle of the DLX decode stage.
// slave = the decode stage, master = the fetch/EX environment driving it.
// Optional build macro: DLX_DECODE_ILLEGAL_TRAP_EN adds out_illegal.
interface dlx_decode_stage_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32
);
   localparam int unsigned RW = $clog2(NREG);

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [4:0]      out_aluop;
   logic [RW-1:0]   out_rs1;
   logic [RW-1:0]   out_rs2;
   logic [RW-1:0]   out_rd;
   logic [XLEN-1:0] out_imm;
   logic            out_imm_sel;
   logic            out_pc_sel;
   logic            out_load;
   logic            out_store;
   logic            out_branch;
   logic            out_jump_reg;
   logic            out_jump_abs;
   logic            hazard_stall;
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
   logic            out_illegal;
`endif

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_aluop, out_rs1, out_rs2, out_rd, out_imm,
      input  out_imm_sel, out_pc_sel, out_load, out_store, out_branch, out_jump_reg,
      input  out_jump_abs, hazard_stall
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
      , input out_illegal
`endif
   );

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, out_aluop, out_rs1, out_rs2, out_rd, out_imm,
      output out_imm_sel, out_pc_sel, out_load, out_store, out_branch, out_jump_reg,
      output out_jump_abs, hazard_stall
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
      , output out_illegal
`endif
   );

endinterface

// File: rtl/dlx_instr_decode.sv
// Pure combinational DLX instruction decoder: word -> decoded bundle plus
// source-operand usage flags for hazard detection.
// Optional build macro: DLX_DECODE_ILLEGAL_TRAP_EN flags unknown opcodes/functs.
module dlx_instr_decode
   import dlx_pkg::*;
(
   input  logic [31:0] instr_i,
   output dec_t        dec_o,
   output logic        rs1_used_o,
   output logic        rs2_used_o
);

   logic [5:0]  op;
   logic [31:0] imm_s;
   logic [31:0] imm_z;
   logic [31:0] imm_j;

   assign op    = instr_i[31:26];
   assign imm_s = {{16{instr_i[15]}}, instr_i[15:0]};
   assign imm_z = {16'h0000, instr_i[15:0]};
   assign imm_j = {{6{instr_i[25]}}, instr_i[25:0]};

   // Field extraction and per-opcode control; unknowns fall out as a NOP with rd=0
   always_comb begin
      dec_o      = '0;
      dec_o.rs1  = instr_i[25:21];
      dec_o.rs2  = instr_i[20:16];
      rs1_used_o = 1'b0;
      rs2_used_o = 1'b0;
      case (op)
         OpRType: begin
            dec_o.aluop = funct_to_alu(instr_i[5:0]);
            if (dec_o.aluop != AluNop) begin
               dec_o.rd   = instr_i[15:11];
               rs1_used_o = 1'b1;
               rs2_used_o = 1'b1;
            end else begin
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
               dec_o.illegal = 1'b1;
`endif
            end
         end
         OpAddi, OpSubi, OpAndi, OpOri, OpXori, OpSlli,
         OpSrli, OpSrai, OpSeqi, OpSnei, OpSlti, OpSgti: begin
            dec_o.aluop   = iop_to_alu(op);
            dec_o.rd      = instr_i[20:16];
            dec_o.imm     = iop_signed(op) ? imm_s : imm_z;
            dec_o.imm_sel = 1'b1;
            rs1_used_o    = 1'b1;
         end
         OpLhi: begin
            dec_o.rd      = instr_i[20:16];
            dec_o.imm     = imm_z;
            dec_o.imm_sel = 1'b1;
         end
         OpLw: begin
            dec_o.aluop   = AluAdd;
            dec_o.rd      = instr_i[20:16];
            dec_o.imm     = imm_s;
            dec_o.imm_sel = 1'b1;
            dec_o.load    = 1'b1;
            rs1_used_o    = 1'b1;
         end
         OpSw: begin
            dec_o.aluop   = AluAdd;
            dec_o.imm     = imm_s;
            dec_o.imm_sel = 1'b1;
            dec_o.store   = 1'b1;
            rs1_used_o    = 1'b1;
            rs2_used_o    = 1'b1;
         end
         OpBeqz, OpBnez: begin
            dec_o.aluop   = (op == OpBeqz) ? AluBeqz : AluBnez;
            dec_o.imm     = imm_s;
            dec_o.imm_sel = 1'b1;
            dec_o.branch  = 1'b1;
            rs1_used_o    = 1'b1;
            rs2_used_o    = 1'b1;
         end
         OpJr, OpJalr: begin
            dec_o.aluop    = (op == OpJalr) ? AluLink : AluNop;
            dec_o.link     = (op == OpJalr);
            dec_o.imm      = imm_z;
            dec_o.imm_sel  = 1'b1;
            dec_o.jump_reg = 1'b1;
            rs1_used_o     = 1'b1;
         end
         OpJ, OpJal: begin
            dec_o.aluop    = (op == OpJal) ? AluLink : AluNop;
            dec_o.link     = (op == OpJal);
            dec_o.imm      = imm_j;
            dec_o.jump_abs = 1'b1;
            dec_o.pc_sel   = 1'b1;
         end
         default: begin
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
            dec_o.illegal = 1'b1;
`endif
         end
      endcase
   end

endmodule

// File: rtl/dlx_decode_stage.sv
// Registered DLX ID stage: decodes fetched instructions into an ID/EX register
// behind valid/ready handshakes, inserts load-use bubbles and honours EX flushes.
// Optional build macro: DLX_DECODE_ILLEGAL_TRAP_EN exports out_illegal.
module dlx_decode_stage
   import dlx_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREG     = 32,
   parameter int unsigned LINK_REG = 31
) (
   input logic               clk,
   input logic               reset,
   dlx_decode_stage_if.slave bus
);

   localparam int unsigned RW = $clog2(NREG);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      aluop_e          aluop;
      logic [RW-1:0]   rs1;
      logic [RW-1:0]   rs2;
      logic [RW-1:0]   rd;
      logic [XLEN-1:0] imm;
      logic            imm_sel;
      logic            pc_sel;
      logic            load;
      logic            store;
      logic            branch;
      logic            jump_reg;
      logic            jump_abs;
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
      logic            illegal;
`endif
   } out_t;

   dec_t          dec;
   logic          rs1_used;
   logic          rs2_used;
   out_t          in_bundle;
   out_t          out_d, out_q;
   logic          out_valid_d, out_valid_q;
   logic          ld_pending_d, ld_pending_q;
   logic [RW-1:0] ld_rd_d, ld_rd_q;
   logic          hz;
   logic          in_ready;
   logic          accept;
   logic          out_fire;

   dlx_instr_decode u_decode (
      .instr_i    (bus.in_instr),
      .dec_o      (dec),
      .rs1_used_o (rs1_used),
      .rs2_used_o (rs2_used)
   );

   // Widen the decoded fields to the stage's register-index and data widths
   always_comb begin
      in_bundle          = '0;
      in_bundle.pc       = bus.in_pc;
      in_bundle.aluop    = dec.aluop;
      in_bundle.rs1      = RW'(dec.rs1);
      in_bundle.rs2      = RW'(dec.rs2);
      in_bundle.rd       = dec.link ? RW'(LINK_REG) : RW'(dec.rd);
      in_bundle.imm      = XLEN'($signed(dec.imm));
      in_bundle.imm_sel  = dec.imm_sel;
      in_bundle.pc_sel   = dec.pc_sel;
      in_bundle.load     = dec.load;
      in_bundle.store    = dec.store;
      in_bundle.branch   = dec.branch;
      in_bundle.jump_reg = dec.jump_reg;
      in_bundle.jump_abs = dec.jump_abs;
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
      in_bundle.illegal  = dec.illegal;
`endif
   end

   // ld_rd_q is never zero while ld_pending_q is set, so r0 never stalls
   assign hz = ld_pending_q && bus.in_valid &&
               ((rs1_used && (in_bundle.rs1 == ld_rd_q)) ||
                (rs2_used && (in_bundle.rs2 == ld_rd_q)));

   assign in_ready = !reset && !bus.flush && !hz && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign out_fire = out_valid_q && bus.out_ready;

   // Next state: flush beats everything, then capture, then drain, else hold
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      ld_pending_d = 1'b0;
      ld_rd_d      = ld_rd_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
      end else begin
         if (out_fire && out_q.load && (out_q.rd != '0)) begin
            ld_pending_d = 1'b1;
            ld_rd_d      = out_q.rd;
         end
         if (accept) begin
            out_d       = in_bundle;
            out_valid_d = 1'b1;
         end else if (out_fire) begin
            out_valid_d = 1'b0;
         end
      end
   end

   // ID/EX pipeline register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         ld_pending_q <= 1'b0;
         ld_rd_q      <= '0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         ld_pending_q <= ld_pending_d;
         ld_rd_q      <= ld_rd_d;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.hazard_stall = hz;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_pc       = out_q.pc;
   assign bus.out_aluop    = out_q.aluop;
   assign bus.out_rs1      = out_q.rs1;
   assign bus.out_rs2      = out_q.rs2;
   assign bus.out_rd       = out_q.rd;
   assign bus.out_imm      = out_q.imm;
   assign bus.out_imm_sel  = out_q.imm_sel;
   assign bus.out_pc_sel   = out_q.pc_sel;
   assign bus.out_load     = out_q.load;
   assign bus.out_store    = out_q.store;
   assign bus.out_branch   = out_q.branch;
   assign bus.out_jump_reg = out_q.jump_reg;
   assign bus.out_jump_abs = out_q.jump_abs;
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
   assign bus.out_illegal  = out_q.illegal;
`endif

endmodule

// File: tb/tb_dlx_decode_stage.sv
// Directed self-checking bench for dlx_decode_stage: a decode vector table
// followed by hand-written hazard, backpressure, flush and reset sequences.
// Honours DLX_DECODE_ILLEGAL_TRAP_EN when checking out_illegal.
module tb_dlx_decode_stage;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   dlx_decode_stage_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

   dlx_decode_stage #(
      .XLEN     (XLEN),
      .NREG     (NREG),
      .LINK_REG (31)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // flags = {imm_sel, pc_sel, load, store, branch, jump_reg, jump_abs}
   typedef struct {
      logic [31:0] instr;
      logic [4:0]  aluop;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [6:0]  flags;
      logic        ill;
   } vec_t;

   vec_t vecs[19];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      bus.in_pc    = pc;
   endtask

   function automatic logic [6:0] out_flags();
      return {bus.out_imm_sel, bus.out_pc_sel, bus.out_load, bus.out_store,
              bus.out_branch, bus.out_jump_reg, bus.out_jump_abs};
   endfunction

   initial begin
      n_cmp = 0;
      n_err = 0;
      vecs[0]  = '{32'h00221820, 5'd1,  5'd1,  5'd2,  5'd3,  32'h00000000, 7'h00, 1'b0}; // ADD
      vecs[1]  = '{32'h00853822, 5'd2,  5'd4,  5'd5,  5'd7,  32'h00000000, 7'h00, 1'b0}; // SUB
      vecs[2]  = '{32'h00430807, 5'd14, 5'd2,  5'd3,  5'd1,  32'h00000000, 7'h00, 1'b0}; // SRA
      vecs[3]  = '{32'h00224829, 5'd13, 5'd1,  5'd2,  5'd9,  32'h00000000, 7'h00, 1'b0}; // SGT
      vecs[4]  = '{32'h0022183F, 5'd0,  5'd1,  5'd2,  5'd0,  32'h00000000, 7'h00, 1'b1}; // bad funct
      vecs[5]  = '{32'h2004FFFF, 5'd1,  5'd0,  5'd4,  5'd4,  32'hFFFFFFFF, 7'h40, 1'b0}; // ADDI -1
      vecs[6]  = '{32'h3004FFFF, 5'd3,  5'd0,  5'd4,  5'd4,  32'h0000FFFF, 7'h40, 1'b0}; // ANDI
      vecs[7]  = '{32'h6822FFF0, 5'd12, 5'd1,  5'd2,  5'd2,  32'hFFFFFFF0, 7'h40, 1'b0}; // SLTI
      vecs[8]  = '{32'h58430004, 5'd7,  5'd2,  5'd3,  5'd3,  32'h00000004, 7'h40, 1'b0}; // SRLI
      vecs[9]  = '{32'h8C250008, 5'd1,  5'd1,  5'd5,  5'd5,  32'h00000008, 7'h50, 1'b0}; // LW
      vecs[10] = '{32'hAC46FFFC, 5'd1,  5'd2,  5'd6,  5'd0,  32'hFFFFFFFC, 7'h48, 1'b0}; // SW
      vecs[11] = '{32'h14600020, 5'd9,  5'd3,  5'd0,  5'd0,  32'h00000020, 7'h44, 1'b0}; // BNEZ
      vecs[12] = '{32'h1060FFF8, 5'd8,  5'd3,  5'd0,  5'd0,  32'hFFFFFFF8, 7'h44, 1'b0}; // BEQZ
      vecs[13] = '{32'h48E00000, 5'd0,  5'd7,  5'd0,  5'd0,  32'h00000000, 7'h42, 1'b0}; // JR
      vecs[14] = '{32'h4CE00000, 5'd15, 5'd7,  5'd0,  5'd31, 32'h00000000, 7'h42, 1'b0}; // JALR
      vecs[15] = '{32'h3C088000, 5'd0,  5'd0,  5'd8,  5'd8,  32'h00008000, 7'h40, 1'b0}; // LHI
      vecs[16] = '{32'h0BFFFFFC, 5'd0,  5'd31, 5'd31, 5'd0,  32'hFFFFFFFC, 7'h21, 1'b0}; // J -4
      vecs[17] = '{32'h0C000010, 5'd15, 5'd0,  5'd0,  5'd31, 32'h00000010, 7'h21, 1'b0}; // JAL
      vecs[18] = '{32'hFC000000, 5'd0,  5'd0,  5'd0,  5'd0,  32'h00000000, 7'h00, 1'b1}; // bad op

      // Reset: an offered instruction is refused and nothing is captured
      reset         = 1'b1;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      drive(32'h00221820, 32'h0000_0010);
      @(negedge clk);
      @(negedge clk); #1;
      chk("reset in_ready", bus.in_ready, 0);
      chk("reset out_valid", bus.out_valid, 0);
      chk("reset out_pc", bus.out_pc, 0);
      chk("reset out_aluop", bus.out_aluop, 0);
      chk("reset out_rd", bus.out_rd, 0);
      chk("reset out_imm", bus.out_imm, 0);
      chk("reset flags", out_flags(), 0);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("post-reset in_ready", bus.in_ready, 1);

      // Decode table, one instruction at a time with idle gaps
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         drive(vecs[i].instr, 32'h1000 + 32'(i) * 4);
         @(negedge clk); #1;
         bus.in_valid = 1'b0;
         chk($sformatf("v%0d valid", i), bus.out_valid, 1);
         chk($sformatf("v%0d pc", i), bus.out_pc, 32'h1000 + 32'(i) * 4);
         chk($sformatf("v%0d aluop", i), bus.out_aluop, vecs[i].aluop);
         chk($sformatf("v%0d rs1", i), bus.out_rs1, vecs[i].rs1);
         chk($sformatf("v%0d rs2", i), bus.out_rs2, vecs[i].rs2);
         chk($sformatf("v%0d rd", i), bus.out_rd, vecs[i].rd);
         chk($sformatf("v%0d imm", i), bus.out_imm, vecs[i].imm);
         chk($sformatf("v%0d flags", i), out_flags(), vecs[i].flags);
`ifdef DLX_DECODE_ILLEGAL_TRAP_EN
         chk($sformatf("v%0d illegal", i), bus.out_illegal, vecs[i].ill);
`endif
         @(negedge clk);
         @(negedge clk); #1;
         chk($sformatf("v%0d drained", i), bus.out_valid, 0);
      end

      // Load-use: LW r5; ADD r3,r1,r2; ADD r6,r5,r0 stalls one cycle behind a bubble
      @(negedge clk);
      drive(32'h8C250000, 32'h200);
      @(negedge clk);
      drive(32'h00221820, 32'h204);
      @(negedge clk);
      drive(32'h00A03020, 32'h208); #1;
      chk("hz stall", bus.hazard_stall, 1);
      chk("hz in_ready", bus.in_ready, 0);
      chk("hz prior rd", bus.out_rd, 3);
      @(negedge clk); #1;
      chk("hz bubble", bus.out_valid, 0);
      chk("hz released", bus.hazard_stall, 0);
      chk("hz accept", bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0; #1;
      chk("hz dep valid", bus.out_valid, 1);
      chk("hz dep rd", bus.out_rd, 6);
      chk("hz dep rs1", bus.out_rs1, 5);
      chk("hz dep pc", bus.out_pc, 32'h208);

      // Backpressure: held three cycles, then one bundle per cycle
      @(negedge clk);
      drive(32'h2004FFFF, 32'h300);
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(32'h3004FFFF, 32'h304);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp%0d in_ready", k), bus.in_ready, 0);
         chk($sformatf("bp%0d valid", k), bus.out_valid, 1);
         chk($sformatf("bp%0d imm", k), bus.out_imm, 32'hFFFFFFFF);
         chk($sformatf("bp%0d pc", k), bus.out_pc, 32'h300);
         @(negedge clk);
      end
      bus.out_ready = 1'b1; #1;
      chk("bp release in_ready", bus.in_ready, 1);
      @(negedge clk);
      drive(32'h00221820, 32'h308); #1;
      chk("bp next imm", bus.out_imm, 32'h0000FFFF);
      chk("bp next pc", bus.out_pc, 32'h304);
      chk("bp next in_ready", bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0; #1;
      chk("bp third valid", bus.out_valid, 1);
      chk("bp third pc", bus.out_pc, 32'h308);
      @(negedge clk); #1;
      chk("bp drained", bus.out_valid, 0);

      // JAL then flush: held bundle and the incoming instruction are both killed
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(32'h0C000010, 32'h400);
      @(negedge clk); #1;
      chk("jal valid", bus.out_valid, 1);
      chk("jal rd", bus.out_rd, 31);
      chk("jal aluop", bus.out_aluop, 15);
      chk("jal jump_abs", bus.out_jump_abs, 1);
      bus.flush = 1'b1;
      drive(32'h00221820, 32'h404); #1;
      chk("flush in_ready", bus.in_ready, 0);
      @(negedge clk);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0; #1;
      chk("flush killed", bus.out_valid, 0);
      @(negedge clk); #1;
      chk("flush dropped", bus.out_valid, 0);
      bus.out_ready = 1'b1;

      // Reset mid-stream while a load fires: no stale load-use stall afterwards
      @(negedge clk);
      drive(32'h8C250000, 32'h500);
      @(negedge clk);
      bus.in_valid = 1'b0;
      reset        = 1'b1; #1;
      chk("mid reset out_valid", bus.out_valid, 1);
      chk("mid reset in_ready", bus.in_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      drive(32'h00A03020, 32'h504); #1;
      chk("mid reset cleared", bus.out_valid, 0);
      chk("mid reset no hz", bus.hazard_stall, 0);
      chk("mid reset accept", bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0; #1;
      chk("mid reset next valid", bus.out_valid, 1);
      chk("mid reset next rd", bus.out_rd, 6);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dlx_decode_stage.md
Name: dlx_decode_stage

Overview:
Registered ID stage for the pipelined DLX. It accepts fetched instructions over a valid/ready handshake and decodes them into ALU-op, register-index, immediate and control fields. Results are held in an ID/EX output register. The stage stalls on load-use hazards and accepts a flush from EX on taken branches/jumps. It generalises the combinational decoder: parametrised widths, registered and handshaked output, hazard and flush control.

Parameters:
XLEN, 32, datapath/PC/immediate width (≥32)
NREG, 32, architectural register count; RW = $clog2(NREG)
LINK_REG, 31, destination register for JAL/JALR

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  fetch offers an instruction
in_ready  out  1  stage accepts this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  PC of instruction
flush  in  1  EX redirect; kill held and incoming instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  EX accepts bundle
out_pc  out  XLEN  registered PC
out_aluop  out  5  ALU op code (pkg enum)
out_rs1, out_rs2, out_rd  out  RW each  register indices; rd=0 means no writeback
out_imm  out  XLEN  sign- or zero-extended immediate
out_imm_sel, out_pc_sel, out_load, out_store, out_branch, out_jump_reg, out_jump_abs  out  1 each  control flags
hazard_stall  out  1  load-use bubble inserted this cycle

Behaviour:
- Reset (sync, clk edge with reset=1): out_valid=0, all out_* fields=0, ld_pending=0, in_ready=0 during reset.
- Decode is combinational on in_instr; capture on in_valid&&in_ready; latency 1 cycle in→out.
- Encodings (pkg). R-type (op=0) funct→aluop: 20 ADD(1), 22 SUB(2), 24 AND(3), 25 OR(4), 26 XOR(5), 04 SLL(6), 06 SRL(7), 07 SRA(14), 28 SEQ(10), 2C SNE(11), 2A SLT(12), 29 SGT(13); rs1=[25:21], rs2=[20:16], rd=[15:11]; unknown funct→aluop 0.
- I-type: same ops at 08/0A/0C/0D/0E/14/16/17/18/1C/1A/19. Sign-extend for ADDI/SUBI/SEQI/SNEI/SLTI/SGTI/LW/SW/BEQZ/BNEZ; zero-extend for logical, shift, LHI, JR, JALR. rd=[20:16]; imm_sel=1.
- Special I-type: LW 23 → ADD, load=1. SW 2B → ADD, store=1, rd=0. BEQZ 04/BNEZ 05 → op 8/9, branch=1, rd=0. JR 12 → jump_reg=1, rd=0. JALR 13 → op 15, rd=LINK_REG, jump_reg=1. LHI 0F → op 0.
- J-type 02 J / 03 JAL: imm = sign-extended [25:0]; jump_abs=1, pc_sel=1. JAL: op 15, rd=LINK_REG.
- Operand use: rs2 counts as read only for R-type, SW and branches. rs1 is read except for J/JAL/LHI.
- Handshake: out holds stable while out_valid&&!out_ready.
- in_ready = !reset && !flush && !hz && (!out_valid || out_ready).
- Load-use: when an out bundle with load=1 and rd≠0 fires, set ld_pending=1 and ld_rd=rd for exactly the next cycle. hz = ld_pending && in_valid && incoming reads ld_rd (rd≠0 only). While hz is high: hazard_stall=1, and if out fires, out_valid drops to 0 (bubble). ld_pending clears next cycle; the instruction is then accepted.
- Flush: next edge out_valid=0, ld_pending=0; in_instr is not accepted that cycle. Flush has priority over capture, hazard and hold.
- Simultaneous fire on both sides: new bundle replaces old (full throughput, 1 instr/cycle).

Optional Feature:
DLX_DECODE_ILLEGAL_TRAP_EN. When defined: extra output out_illegal (1) is set for an unknown opcode or R-funct. Such a bundle passes with rd=0, load=store=0. When undefined: no port; unknowns decode as NOP (aluop 0, rd=0).

Decomposition:
- Package dlx_pkg holds: the aluop enum (0..15), the opcode/funct localparams, and a decoded-bundle packed struct.
- Sub-module dlx_instr_decode: pure combinational word→bundle decode, plus rs1_used/rs2_used.
- The top holds the pipeline register, handshake, hazard and flush logic.

Test Plan:
- ADD r3,r1,r2 (0x00221820), out_ready=1 → next cycle out_valid=1, aluop=1, rs1=1, rs2=2, rd=3.
- ADDI r4,r0,-1 (0x2004FFFF) → imm=0xFFFFFFFF, imm_sel=1, rd=4. ANDI same imm → imm=0x0000FFFF.
- LW r5,0(r1), then ADD r6,r5,r0 → hazard_stall=1 for one cycle, bubble out_valid=0, ADD emitted the cycle after.
- out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and out fields stable; release → one bundle per cycle resumes.
- JAL +0x10 (0x0C000010) → rd=31, aluop=15, jump_abs=1. flush next cycle → out_valid=0, following instruction dropped.
- reset asserted mid-stream with out_valid=1 → next edge out_valid=0, ld_pending cleared. With the macro defined, opcode 0x3F → out_illegal=1.
